// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target port for the j1a; two IO-mapped byte
// registers with UART-style handshakes, pins oversampled by clk.
//
// Ports:
//   clk, resetq          system clock, async active-low reset
//   sck, cs_n, mosi      SPI pins from the host (asynchronous)
//   miso, miso_oe        SPI data out and its SB_IO output enable
//   wr, tx_data          queue a byte for the host
//   tx_ready             TX holding buffer empty
//   rd                   consume rx_data
//   rx_data, rx_valid    last complete received byte, unread flag
//   overrun              sticky: byte completed while rx_valid was set
//   selected             synchronized chip select active
module spi_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       wr,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       selected
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] r_sck_s;
    logic [SYNC_STAGES-1:0] r_cs_s;
    logic [SYNC_STAGES-1:0] r_mosi_s;
    logic                   r_sck_d;
    logic                   r_cs_d;

    logic [0:0] r_state;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift_in;
    logic [7:0] r_shift_out;
    logic [7:0] r_tx_buf;
    logic       r_tx_full;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_overrun;
    logic       r_miso;
    logic       r_miso_oe;

    logic       w_sck;
    logic       w_cs;
    logic       w_mosi;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_shift;
    logic       w_load;
    logic       w_done;
    logic [7:0] w_next;

    assign w_sck  = r_sck_s[SYNC_STAGES-1];
    assign w_cs   = r_cs_s[SYNC_STAGES-1];
    assign w_mosi = r_mosi_s[SYNC_STAGES-1];

    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_cs_fall  = ~w_cs & r_cs_d;
    assign w_cs_rise  = w_cs & ~r_cs_d;

    // Deselect overrides any sck edge seen in the same cycle.
    assign w_shift = (r_state == SHIFT) & ~w_cs_rise;

    // Byte loads happen at select and at every byte boundary.
    assign w_load = ((r_state == IDLE) & w_cs_fall)
                  | (w_shift & w_sck_fall & (r_bitcnt == 3'd0));
    assign w_done = w_shift & w_sck_rise & (r_bitcnt == 3'd7);
    assign w_next = r_tx_full ? r_tx_buf : IDLE_BYTE;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_sck_s  <= '0;
            r_cs_s   <= '1;
            r_mosi_s <= '0;
            r_sck_d  <= 1'b0;
            r_cs_d   <= 1'b1;
        end else begin
            r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], sck};
            r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], cs_n};
            r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], mosi};
            r_sck_d  <= w_sck;
            r_cs_d   <= w_cs;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state     <= IDLE;
            r_bitcnt    <= 3'd0;
            r_shift_in  <= 8'd0;
            r_shift_out <= 8'd0;
            r_tx_buf    <= 8'd0;
            r_tx_full   <= 1'b0;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
        end else begin
            // A completing byte beats a same-cycle rd.
            if (w_done) begin
                r_rx_data  <= {r_shift_in[6:0], w_mosi};
                r_rx_valid <= 1'b1;
                r_overrun  <= ~rd & (r_overrun | r_rx_valid);
            end else if (rd) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end

            // Load sees the old buffer; a same-cycle wr refills it.
            if (w_load) begin
                r_shift_out <= w_next;
                r_miso      <= w_next[7];
                r_tx_full   <= 1'b0;
            end
            if (wr) begin
                r_tx_buf  <= tx_data;
                r_tx_full <= 1'b1;
            end

            if (r_state == IDLE) begin
                if (w_cs_fall) begin
                    r_state   <= SHIFT;
                    r_bitcnt  <= 3'd0;
                    r_miso_oe <= 1'b1;
                end
            end else if (w_cs_rise) begin
                r_state   <= IDLE;
                r_bitcnt  <= 3'd0;
                r_miso_oe <= 1'b0;
                r_miso    <= 1'b0;
            end else if (w_sck_rise) begin
                r_shift_in <= {r_shift_in[6:0], w_mosi};
                r_bitcnt   <= r_bitcnt + 3'd1;
            end else if (w_sck_fall && r_bitcnt != 3'd0) begin
                r_shift_out <= {r_shift_out[6:0], 1'b0};
                r_miso      <= r_shift_out[6];
            end
        end
    end

    assign miso     = r_miso;
    assign miso_oe  = r_miso_oe;
    assign tx_ready = ~r_tx_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign overrun  = r_overrun;
    assign selected = ~w_cs;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed and randomized SPI host transfers against
// a byte-level model of the target's TX buffer and RX handshake.
module tb_spi_target;

    localparam int S    = 2;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       rd = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       selected;

    spi_target #(.SYNC_STAGES(S), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .resetq(resetq), .sck(sck), .cs_n(cs_n),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .wr(wr),
        .tx_data(tx_data), .tx_ready(tx_ready), .rd(rd),
        .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
        .selected(selected)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_chk  = 0;

    // Reference model: holding buffer as a queue of depth <= 1.
    logic [7:0] tx_q[$];
    logic [7:0] m_rx = 8'd0;
    logic       m_rv = 1'b0;
    logic       m_ov = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic m_wr(input logic [7:0] b);
        if (tx_q.size() > 0) tx_q[0] = b;
        else tx_q.push_back(b);
    endtask

    function automatic logic [7:0] m_start();
        if (tx_q.size() > 0) return tx_q.pop_front();
        return 8'hFF;
    endfunction

    task automatic m_done(input logic [7:0] b, input bit rd_same);
        m_ov = rd_same ? 1'b0 : (m_ov | m_rv);
        m_rx = b;
        m_rv = 1'b1;
    endtask

    task automatic half();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic do_wr(input logic [7:0] b);
        @(negedge clk);
        wr = 1'b1;
        tx_data = b;
        @(negedge clk);
        wr = 1'b0;
        m_wr(b);
    endtask

    task automatic do_rd();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        m_rv = 1'b0;
        m_ov = 1'b0;
    endtask

    // Mode-0 host: mosi set while sck low, miso sampled at rise.
    task automatic xfer(input logic [7:0] mo, input int nbits,
                        input int wr_at, input logic [7:0] wr_b,
                        input bit rd_last, output logic [7:0] mi);
        mi = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            if (i == wr_at) begin
                wr = 1'b1;
                tx_data = wr_b;
                @(negedge clk);
                wr = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                half();
            end
            mi[7-i] = miso;
            sck = 1'b1;
            if (rd_last && i == nbits - 1) begin
                repeat (S) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
                repeat (HALF - S - 1) @(negedge clk);
            end else begin
                half();
            end
            sck = 1'b0;
        end
    endtask

    task automatic deselect();
        half();
        cs_n = 1'b1;
        half();
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".rx_data"}, rx_data, m_rx);
        chk({tag, ".rx_valid"}, {7'd0, rx_valid}, {7'd0, m_rv});
        chk({tag, ".overrun"}, {7'd0, overrun}, {7'd0, m_ov});
        chk({tag, ".tx_ready"}, {7'd0, tx_ready},
            {7'd0, tx_q.size() == 0});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rx_data"}, rx_data, 8'd0);
        chk({tag, ".rx_valid"}, {7'd0, rx_valid}, 8'd0);
        chk({tag, ".overrun"}, {7'd0, overrun}, 8'd0);
        chk({tag, ".tx_ready"}, {7'd0, tx_ready}, 8'd1);
        chk({tag, ".miso_oe"}, {7'd0, miso_oe}, 8'd0);
        chk({tag, ".miso"}, {7'd0, miso}, 8'd0);
        chk({tag, ".selected"}, {7'd0, selected}, 8'd0);
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] mo;
        logic [7:0] ex;
        int nb;

        repeat (3) @(negedge clk);
        chk_reset("rst");
        resetq = 1'b1;
        repeat (4) @(negedge clk);

        // sck activity while deselected is ignored
        for (int k = 0; k < 16; k++) begin
            sck = ~sck;
            half();
            chk("idle.rx_valid", {7'd0, rx_valid}, 8'd0);
            chk("idle.miso_oe", {7'd0, miso_oe}, 8'd0);
            chk("idle.tx_ready", {7'd0, tx_ready}, 8'd1);
        end

        // single byte exchange
        do_wr(8'hA5);
        cs_n = 1'b0;
        ex = m_start();
        xfer(8'h3C, 8, -1, 8'h00, 1'b0, mi);
        m_done(8'h3C, 1'b0);
        chk("a5.miso", mi, 8'hA5);
        chk("a5.model", mi, ex);
        chk("a5.tx_ready", {7'd0, tx_ready}, 8'd1);
        chk("a5.selected", {7'd0, selected}, 8'd1);
        chk("a5.miso_oe", {7'd0, miso_oe}, 8'd1);
        deselect();
        chk("a5.rx_data", rx_data, 8'h3C);
        chk("a5.rx_valid", {7'd0, rx_valid}, 8'd1);
        chk("a5.selected_off", {7'd0, selected}, 8'd0);
        do_rd();
        chk("a5.rd", {7'd0, rx_valid}, 8'd0);

        // two bytes, no TX data, no rd -> overrun
        cs_n = 1'b0;
        ex = m_start();
        xfer(8'h01, 8, -1, 8'h00, 1'b0, mi);
        m_done(8'h01, 1'b0);
        chk("ov.miso0", mi, 8'hFF);
        ex = m_start();
        xfer(8'h02, 8, -1, 8'h00, 1'b0, mi);
        m_done(8'h02, 1'b0);
        chk("ov.miso1", mi, 8'hFF);
        deselect();
        chk("ov.rx_data", rx_data, 8'h02);
        chk("ov.overrun", {7'd0, overrun}, 8'd1);
        chk_model("ov");
        do_rd();
        chk("ov.rd", {7'd0, overrun}, 8'd0);

        // refill during a byte
        do_wr(8'h11);
        cs_n = 1'b0;
        ex = m_start();
        xfer(8'h96, 8, 3, 8'h22, 1'b0, mi);
        m_wr(8'h22);
        m_done(8'h96, 1'b0);
        chk("refill.b0", mi, 8'h11);
        chk("refill.full", {7'd0, tx_ready}, 8'd0);
        ex = m_start();
        half();
        chk("refill.ready", {7'd0, tx_ready}, 8'd1);
        xfer(8'h69, 8, -1, 8'h00, 1'b0, mi);
        m_done(8'h69, 1'b0);
        chk("refill.b1", mi, 8'h22);
        chk("refill.b1m", mi, ex);
        deselect();
        chk_model("refill");
        do_rd();

        // aborted byte then full byte
        cs_n = 1'b0;
        ex = m_start();
        xfer(8'hF0, 5, -1, 8'h00, 1'b0, mi);
        half();
        cs_n = 1'b1;
        repeat (S + 2) @(negedge clk);
        chk("abort.miso_oe", {7'd0, miso_oe}, 8'd0);
        chk("abort.miso", {7'd0, miso}, 8'd0);
        chk("abort.rx_valid", {7'd0, rx_valid}, 8'd0);
        half();
        cs_n = 1'b0;
        ex = m_start();
        xfer(8'h81, 8, -1, 8'h00, 1'b0, mi);
        m_done(8'h81, 1'b0);
        deselect();
        chk("abort.rx_data", rx_data, 8'h81);
        chk_model("abort");

        // rd lands on the completion cycle: new byte wins
        cs_n = 1'b0;
        ex = m_start();
        xfer(8'h5A, 8, -1, 8'h00, 1'b1, mi);
        m_done(8'h5A, 1'b1);
        deselect();
        chk("rdhit.rx_valid", {7'd0, rx_valid}, 8'd1);
        chk("rdhit.rx_data", rx_data, 8'h5A);
        chk("rdhit.overrun", {7'd0, overrun}, 8'd0);

        // randomized transfers
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(1, 0) == 1) do_wr(8'($urandom));
            cs_n = 1'b0;
            nb = int'($urandom_range(2, 1));
            for (int b = 0; b < nb; b++) begin
                mo = 8'($urandom);
                ex = m_start();
                xfer(mo, 8, -1, 8'h00, 1'b0, mi);
                m_done(mo, 1'b0);
                chk("rnd.miso", mi, ex);
            end
            deselect();
            if ($urandom_range(1, 0) == 1) do_rd();
            chk_model("rnd");
        end

        // reset mid-byte
        do_wr(8'h77);
        cs_n = 1'b0;
        xfer(8'hC3, 4, -1, 8'h00, 1'b0, mi);
        do_wr(8'h66);
        resetq = 1'b0;
        #1;
        chk_reset("midrst");
        cs_n = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        repeat (10) @(negedge clk);
        chk("post.miso_oe", {7'd0, miso_oe}, 8'd0);
        chk("post.selected", {7'd0, selected}, 8'd0);
        chk("post.tx_ready", {7'd0, tx_ready}, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
